// File: rtl/imc22_npu_tile_seq.sv
// Job-level tile sequencer for the IMC-22 16-lane NPU dot-product engine.
// Programs weight/input bases per tile, starts the NPU and accumulates results.
module imc22_npu_tile_seq #(
    parameter int          TIMEOUT    = 1024,
    parameter int          W_STRIDE   = 1,
    parameter int          I_STRIDE   = 1,
    parameter logic [7:0]  ADDR_WBASE = 8'h04,
    parameter logic [7:0]  ADDR_IBASE = 8'h08
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_start,
    input  logic [7:0]  job_tiles,
    input  logic [9:0]  job_wbase,
    input  logic [9:0]  job_ibase,
    input  logic        job_abort,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_err,
    output logic [31:0] job_result,
    output logic [7:0]  tiles_done,
    output logic [7:0]  npu_cfg_addr,
    output logic [31:0] npu_cfg_wdata,
    output logic        npu_cfg_wr,
    output logic        npu_start,
    input  logic        npu_done,
    input  logic [31:0] npu_result
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_W, S_CFG_I, S_START, S_WAIT, S_DRAIN, S_DONE
    } state_t;

    localparam int             TW     = $clog2(TIMEOUT + 1);
    // Leaving when the timer would next read TIMEOUT-1.
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 2);
    localparam logic [9:0]     WS     = 10'(W_STRIDE);
    localparam logic [9:0]     IS     = 10'(I_STRIDE);

    state_t        state, state_nx;
    logic [7:0]    ntiles;
    logic [9:0]    wptr, iptr;
    logic [TW-1:0] timer;
    logic [31:0]   acc;
    logic          err;
    logic          last_tile, tmo;

    assign last_tile  = (tiles_done + 8'd1) == ntiles;
    assign tmo        = timer == T_LAST;
    assign job_result = acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (job_start) state_nx = (job_tiles == 8'd0) ? S_DONE : S_CFG_W;
            S_CFG_W: state_nx = job_abort ? S_DONE : S_CFG_I;
            S_CFG_I: state_nx = job_abort ? S_DONE : S_START;
            S_START: state_nx = job_abort ? S_DONE : S_WAIT;
            S_WAIT: begin
                // An NPU that already finished need not be drained.
                if (job_abort)     state_nx = npu_done ? S_DONE : S_DRAIN;
                else if (npu_done) state_nx = last_tile ? S_DONE : S_CFG_W;
                else if (tmo)      state_nx = S_DONE;
            end
            S_DRAIN: if (npu_done || tmo) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        npu_cfg_wr    = 1'b0;
        npu_cfg_addr  = 8'h00;
        npu_cfg_wdata = 32'h0;
        npu_start     = 1'b0;
        job_done      = 1'b0;
        job_err       = 1'b0;
        job_busy      = (state != S_IDLE) && (state != S_DONE);
        unique case (state)
            S_CFG_W: begin
                npu_cfg_wr    = !job_abort;
                npu_cfg_addr  = ADDR_WBASE;
                npu_cfg_wdata = {22'b0, wptr};
            end
            S_CFG_I: begin
                npu_cfg_wr    = !job_abort;
                npu_cfg_addr  = ADDR_IBASE;
                npu_cfg_wdata = {22'b0, iptr};
            end
            S_START: npu_start = !job_abort;
            S_DONE: begin
                job_done = 1'b1;
                job_err  = err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ntiles     <= 8'd0;
            wptr       <= 10'd0;
            iptr       <= 10'd0;
            timer      <= '0;
            acc        <= 32'd0;
            tiles_done <= 8'd0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (job_start) begin
                    ntiles     <= job_tiles;
                    wptr       <= job_wbase;
                    iptr       <= job_ibase;
                    timer      <= '0;
                    acc        <= 32'd0;
                    tiles_done <= 8'd0;
                    err        <= 1'b0;
                end
                S_CFG_W, S_CFG_I: if (job_abort) err <= 1'b1;
                S_START: begin
                    timer <= '0;
                    if (job_abort) err <= 1'b1;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (job_abort) begin
                        err <= 1'b1;
                    end else if (npu_done) begin
                        acc        <= acc + npu_result;
                        tiles_done <= tiles_done + 8'd1;
                        if (!last_tile) begin
                            wptr <= wptr + WS;
                            iptr <= iptr + IS;
                        end
                    end else if (tmo) begin
                        err <= 1'b1;
                    end
                end
                S_DRAIN: timer <= timer + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imc22_npu_tile_seq.sv
// Randomized scoreboard bench for imc22_npu_tile_seq with a behavioural
// NPU model and per-job reference of config writes and final outcome.
module tb_imc22_npu_tile_seq;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_start, job_abort;
    logic [7:0]  job_tiles;
    logic [9:0]  job_wbase, job_ibase;
    logic        job_busy, job_done, job_err;
    logic [31:0] job_result;
    logic [7:0]  tiles_done;
    logic [7:0]  npu_cfg_addr;
    logic [31:0] npu_cfg_wdata;
    logic        npu_cfg_wr, npu_start, npu_done;
    logic [31:0] npu_result;

    imc22_npu_tile_seq #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .job_start(job_start), .job_tiles(job_tiles),
        .job_wbase(job_wbase), .job_ibase(job_ibase),
        .job_abort(job_abort), .job_busy(job_busy),
        .job_done(job_done), .job_err(job_err),
        .job_result(job_result), .tiles_done(tiles_done),
        .npu_cfg_addr(npu_cfg_addr), .npu_cfg_wdata(npu_cfg_wdata),
        .npu_cfg_wr(npu_cfg_wr), .npu_start(npu_start),
        .npu_done(npu_done), .npu_result(npu_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } cfg_t;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
        logic [7:0]  tiles;
        logic [1:0]  kind;
    } out_t;

    cfg_t        cfg_q[$];
    out_t        out_q[$];
    logic [31:0] nres_q[$];
    int          nlat_q[$];

    int cyc = 0;
    int checks = 0, errors = 0;
    int exp_starts = 0, seen_starts = 0;
    int last_start_cyc = 0, job_start_cyc = 0;
    logic [31:0] fixv[4];
    int nfix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        cfg_t e;
        out_t o;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (npu_cfg_wr || npu_start)
                    chk("wr_start_overlap", 64'(npu_cfg_wr & npu_start), 64'd0);
                if (npu_cfg_wr) begin
                    if (cfg_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL cfg_unexpected: got addr %0h data %0h expected none",
                                 npu_cfg_addr, npu_cfg_wdata);
                    end else begin
                        e = cfg_q.pop_front();
                        chk("cfg_addr", 64'(npu_cfg_addr), 64'(e.a));
                        chk("cfg_data", 64'(npu_cfg_wdata), 64'(e.d));
                    end
                end
                if (npu_start) begin
                    seen_starts++;
                    last_start_cyc = cyc;
                end
                if (job_done) begin
                    if (out_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got job_done=1 expected none");
                    end else begin
                        o = out_q.pop_front();
                        chk("job_result", 64'(job_result), 64'(o.res));
                        chk("job_err", 64'(job_err), 64'(o.err));
                        chk("tiles_done", 64'(tiles_done), 64'(o.tiles));
                        chk("busy_at_done", 64'(job_busy), 64'd0);
                        if (o.kind == 2'd1)
                            chk("zero_tile_lat", 64'(cyc - job_start_cyc), 64'd1);
                        if (o.kind == 2'd2)
                            chk("timeout_lat", 64'(cyc - last_start_cyc), 64'(TO));
                    end
                end
            end
        end
    end

    // Behavioural NPU: latency 0 means it never answers
    initial begin
        int lat;
        logic [31:0] v;
        npu_done = 1'b0;
        npu_result = 32'h0;
        forever begin
            @(negedge clk);
            if (npu_start && !rst) begin
                if (nres_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL npu_start_unexpected: got start expected none");
                end else begin
                    v = nres_q.pop_front();
                    lat = nlat_q.pop_front();
                    if (lat > 0) begin
                        repeat (lat - 1) @(negedge clk);
                        npu_done = 1'b1;
                        npu_result = v;
                        @(negedge clk);
                        npu_done = 1'b0;
                        npu_result = $urandom;
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // mode 0 normal, 1 NPU silent, 2 abort in WAIT of tile ak, 3 reset in WAIT of tile ak
    task automatic run_job(input int tiles, input logic [9:0] wb, input logic [9:0] ib,
                           input int mode, input int ak);
        logic [31:0] sum, v;
        logic [9:0]  w, i;
        int          n, k, g;
        out_t        o;
        sum = 32'd0;
        n = (mode == 0) ? tiles : (mode == 1) ? 1 : ak + 1;
        for (int t = 0; t < n; t++) begin
            w = wb + 10'(t);
            i = ib + 10'(t);
            cfg_q.push_back({8'h04, 22'b0, w});
            cfg_q.push_back({8'h08, 22'b0, i});
            v = (t < nfix) ? fixv[t] : $urandom;
            nres_q.push_back(v);
            if (mode == 1 || (mode == 3 && t == ak)) nlat_q.push_back(0);
            else if (mode == 2 && t == ak)           nlat_q.push_back(5);
            else                                     nlat_q.push_back($urandom_range(2, 6));
            if (mode == 0 || t < ak) sum = sum + v;
        end
        exp_starts += n;
        o.res = sum; o.err = 1'b0; o.tiles = 8'(tiles);
        o.kind = (tiles == 0) ? 2'd1 : 2'd0;
        if (mode == 1) begin o.res = 0; o.err = 1'b1; o.tiles = 0; o.kind = 2'd2; end
        if (mode == 2) begin o.err = 1'b1; o.tiles = 8'(ak); end
        if (mode != 3) out_q.push_back(o);

        @(negedge clk);
        job_start = 1'b1;
        job_tiles = 8'(tiles);
        job_wbase = wb;
        job_ibase = ib;
        job_start_cyc = cyc;
        @(negedge clk);
        job_start = 1'b0;
        job_tiles = 8'($urandom);

        if (mode >= 2) begin
            k = 0; g = 0;
            while (k <= ak && g < 2000) begin
                if (npu_start) k++;
                if (k <= ak) begin @(negedge clk); g++; end
            end
            if (g >= 2000) chk("wait_start_bound", 64'(g), 64'd0);
            if (mode == 2) begin
                @(negedge clk);
                job_abort = 1'b1;
                chk("busy_mid_job", 64'(job_busy), 64'd1);
                @(negedge clk);
                job_abort = 1'b0;
                job_start = 1'b1;
                job_tiles = 8'd0;
                @(negedge clk);
                job_start = 1'b0;
            end else begin
                repeat (2) @(negedge clk);
                rst = 1'b1;
                #1;
                chk("rst_result", 64'(job_result), 64'd0);
                chk("rst_wdata", 64'(npu_cfg_wdata), 64'd0);
                chk("rst_ctl", 64'({job_busy, job_done, job_err, tiles_done,
                                    npu_cfg_addr, npu_cfg_wr, npu_start}), 64'd0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (4) @(negedge clk);
            end
        end

        if (mode != 3) begin
            g = 0;
            while (!job_done && g < 5000) begin @(negedge clk); g++; end
            if (g >= 5000) chk("wait_done_bound", 64'(g), 64'd0);
            @(negedge clk);
        end
        nfix = 0;
    endtask

    initial begin
        rst = 1'b1;
        job_start = 1'b0; job_abort = 1'b0;
        job_tiles = 8'd0; job_wbase = 10'd0; job_ibase = 10'd0;
        repeat (3) @(negedge clk);
        chk("reset_result", 64'(job_result), 64'd0);
        chk("reset_ctl", 64'({job_busy, job_done, job_err, tiles_done,
                              npu_cfg_wr, npu_start}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'({job_busy, job_done, npu_cfg_wr}), 64'd0);

        fixv[0] = 32'd100; nfix = 1;
        run_job(1, 10'd0, 10'd256, 0, 0);

        fixv[0] = 32'd5; fixv[1] = -32'sd7; fixv[2] = 32'd2; nfix = 3;
        run_job(3, 10'd1022, 10'd10, 0, 0);

        run_job(0, 10'd5, 10'd6, 0, 0);
        run_job(2, 10'd40, 10'd80, 1, 0);
        run_job(4, 10'd100, 10'd200, 2, 1);

        fixv[0] = 32'h7FFF_FFFF; fixv[1] = 32'd1; nfix = 2;
        run_job(2, 10'd3, 10'd4, 0, 0);

        fixv[0] = 32'h1234_5678; nfix = 1;
        run_job(3, 10'd7, 10'd9, 3, 1);

        for (int j = 0; j < 8; j++)
            run_job($urandom_range(1, 5), 10'($urandom), 10'($urandom), 0, 0);
        run_job(5, 10'($urandom), 10'($urandom), 2, $urandom_range(0, 4));
        run_job(3, 10'($urandom), 10'($urandom), 0, 0);

        repeat (10) @(negedge clk);
        chk("cfg_q_empty", 64'(cfg_q.size()), 64'd0);
        chk("out_q_empty", 64'(out_q.size()), 64'd0);
        chk("npu_q_empty", 64'(nres_q.size()), 64'd0);
        chk("start_count", 64'(seen_starts), 64'(exp_starts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
